// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encoding and the requester index constants.
package reg_file_wr_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester indices; also the values stored in the round-robin pointer.
  localparam logic [0:0] REQ0 = 1'b0;
  localparam logic [0:0] REQ1 = 1'b1;

  // Pointer value after reset, chosen so requester 0 wins the first contention.
  localparam logic [0:0] LAST_RESET = REQ1;

  // One-hot grant vector values.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/reg_file_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from two request
// bits and the index of the requester granted most recently.
module rr_arb2
  import reg_file_wr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assigning a default before the case means every path writes
    // grant, so no latch can be inferred for uncovered request patterns.
    grant = GRANT_NONE;
    case (req)
      2'b01:   grant = GRANT_0;
      2'b10:   grant = GRANT_1;
      2'b11:   grant = (last == REQ1) ? GRANT_0 : GRANT_1;
      default: grant = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Owns the register file write port: zero-fills every entry after reset,
// then shares the port between two req/ack requesters in round-robin order.
module reg_file_wr_arbiter
  import reg_file_wr_arbiter_pkg::*;
#(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] addr0,
  input  logic [B-1:0] data0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] addr1,
  input  logic [B-1:0] data1,
  output logic         ack1,
  output logic         init_busy,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [B-1:0] w_data
);

  state_t       state, state_n;
  logic [W:0]   cnt, cnt_n;
  logic         last, last_n;
  logic         wr_en_n, ack0_n, ack1_n, init_busy_n;
  logic [W-1:0] w_addr_n;
  logic [B-1:0] w_data_n;

  logic [1:0]   elig;
  logic [1:0]   grant;

  // A requester whose ack is high this cycle is still holding the request it
  // just completed; masking it stops the same write being issued twice.
  assign elig = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_rr_arb2 (
    .req   (elig),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    wr_en_n     = 1'b0;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    init_busy_n = init_busy;
    w_addr_n    = w_addr;
    w_data_n    = w_data;

    case (state)
      ST_INIT: begin
        // The extra counter bit sets exactly when all 2**W entries are issued.
        if (!cnt[W]) begin
          wr_en_n     = 1'b1;
          w_addr_n    = cnt[W-1:0];
          w_data_n    = '0;
          cnt_n       = cnt + (W+1)'(1);
          init_busy_n = 1'b1;
        end else begin
          init_busy_n = 1'b0;
          state_n     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (grant[REQ0]) begin
          wr_en_n  = 1'b1;
          w_addr_n = addr0;
          w_data_n = data0;
          ack0_n   = 1'b1;
          last_n   = REQ0;
        end else if (grant[REQ1]) begin
          wr_en_n  = 1'b1;
          w_addr_n = addr1;
          w_data_n = data1;
          ack1_n   = 1'b1;
          last_n   = REQ1;
        end
      end

      default: state_n = ST_INIT;
    endcase
  end

  // The register file itself has no reset; its contents are cleared by the
  // write sequence above rather than by a reset on the storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      last      <= LAST_RESET;
      wr_en     <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      wr_en     <= wr_en_n;
      w_addr    <= w_addr_n;
      w_data    <= w_data_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      init_busy <= init_busy_n;
    end
  end

  ack_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(ack0 && ack1));

  ack_implies_write : assert property (@(posedge clk) disable iff (reset)
    (ack0 || ack1) |-> wr_en);

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Scoreboard bench for reg_file_wr_arbiter with a register-file array model,
// directed scenarios followed by randomized requester traffic.
module tb_reg_file_wr_arbiter;

  localparam int B     = 8;
  localparam int W     = 2;
  localparam int DEPTH = 2**W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] addr0 = '0, addr1 = '0;
  logic [B-1:0] data0 = '0, data1 = '0;
  logic         ack0, ack1, init_busy, wr_en;
  logic [W-1:0] w_addr;
  logic [B-1:0] w_data;

  always #5 clk = ~clk;

  reg_file_wr_arbiter #(.B(B), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .addr0     (addr0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .addr1     (addr1),
    .data1     (data1),
    .ack1      (ack1),
    .init_busy (init_busy),
    .wr_en     (wr_en),
    .w_addr    (w_addr),
    .w_data    (w_data)
  );

  // Register file fed by the arbiter, pre-loaded so the clear is observable.
  logic [B-1:0] mem [DEPTH] = '{default: 8'hFF};
  always @(posedge clk) if (wr_en) mem[w_addr] <= w_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           cyc;
    logic [W-1:0] addr;
    logic [B-1:0] data;
    int           src;   // -1 clear write, 0/1 requester
  } wr_t;

  wr_t          exp_q[$];
  int           cyc = 0;
  logic [B-1:0] ref_mem [DEPTH] = '{default: 8'hFF};
  bit           m_init = 1'b1;
  int           m_clear_next = 0;
  int           m_last = 1;
  bit [1:0]     m_prev_ack = '0;
  bit           exp_busy = 1'b1;
  bit           exp_rst = 1'b1;
  bit           pend_v = 1'b0;
  logic [W-1:0] pend_a;
  logic [B-1:0] pend_d;

  always @(posedge clk) begin
    bit e0, e1;
    int win;
    cyc++;
    // The write presented during the previous cycle lands on this edge.
    if (pend_v) ref_mem[pend_a] = pend_d;
    pend_v  = 1'b0;
    exp_rst = reset;
    win     = -1;
    if (reset) begin
      m_init       = 1'b1;
      m_clear_next = 0;
      m_last       = 1;
      m_prev_ack   = '0;
      exp_busy     = 1'b1;
    end else if (m_init) begin
      if (m_clear_next < DEPTH) begin
        exp_q.push_back('{cyc, W'(m_clear_next), '0, -1});
        pend_v = 1'b1; pend_a = W'(m_clear_next); pend_d = '0;
        m_clear_next++;
      end else begin
        m_init   = 1'b0;
        exp_busy = 1'b0;
      end
    end else begin
      e0 = req0 && !m_prev_ack[0];
      e1 = req1 && !m_prev_ack[1];
      if (e0 && e1)  win = 1 - m_last;
      else if (e0)   win = 0;
      else if (e1)   win = 1;
      m_prev_ack = '0;
      if (win >= 0) begin
        m_prev_ack[win] = 1'b1;
        m_last = win;
        pend_v = 1'b1;
        pend_a = (win == 0) ? addr0 : addr1;
        pend_d = (win == 0) ? data0 : data1;
        exp_q.push_back('{cyc, pend_a, pend_d, win});
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("ack_exclusive", ack0 && ack1, 0);
    check("init_busy", init_busy, exp_busy);
    if (exp_rst) begin
      check("reset_w_addr", w_addr, 0);
      check("reset_w_data", w_data, 0);
    end
    if (wr_en) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", w_addr, e.addr);
        check("wr_data", w_data, e.data);
        check("wr_ack0", ack0, e.src == 0);
        check("wr_ack1", ack1, e.src == 1);
      end
    end else begin
      check("ack_without_wr", ack0 || ack1, 0);
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        check("missing_write", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int who, input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = (who == 0) ? ack0 : ack1;
      n    = i + 1;
    end
    check((who == 0) ? "ack0_timeout" : "ack1_timeout", seen, 1);
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("mem%0d", i), mem[i], ref_mem[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, c1, cw, first;
    bit done0, done1;

    // Clear sequence with req0 already pending.
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ack(0, 20, n);
    check("first_grant_latency", n, 6);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("entry2_a5", mem[2], 8'hA5);
    check_mem();

    // Both requesters held: strict alternation.
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd2; data1 = 8'h22;
    c0 = 0; c1 = 0; cw = 0;
    repeat (8) begin
      @(negedge clk);
      c0 += int'(ack0); c1 += int'(ack1); cw += int'(wr_en);
    end
    check("alt_ack0_count", c0, 4);
    check("alt_ack1_count", c1, 4);
    check("alt_wr_count", cw, 8);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Prior ack1, then same-address contention.
    req1 = 1'b1; addr1 = 2'd0; data1 = 8'h77;
    wait_ack(1, 5, n);
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'h33;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h44;
    done0 = 0; done1 = 0; first = -1;
    for (int i = 0; i < 10 && !(done0 && done1); i++) begin
      @(negedge clk);
      if (ack0) begin req0 = 1'b0; done0 = 1; if (first < 0) first = 0; end
      if (ack1) begin req1 = 1'b0; done1 = 1; if (first < 0) first = 1; end
    end
    check("same_addr_first", first, 0);
    check("same_addr_both_done", done0 && done1, 1);
    repeat (2) @(negedge clk);
    check("entry3_44", mem[3], 8'h44);
    check_mem();

    // Single requester held: one write every other cycle.
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h5A;
    c1 = 0; cw = 0;
    repeat (8) begin
      @(negedge clk);
      c1 += int'(ack1); cw += int'(wr_en);
    end
    check("single_ack1_count", c1, 4);
    check("single_wr_count", cw, 4);
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic obeying the requester rule.
    repeat (400) begin
      @(negedge clk);
      if (req0 ? ack0 : ($urandom_range(0, 1) == 1)) begin
        req0  = (req0 && ack0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        addr0 = W'($urandom_range(0, DEPTH-1));
        data0 = B'($urandom);
      end
      if (req1 ? ack1 : ($urandom_range(0, 1) == 1)) begin
        req1  = (req1 && ack1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        addr1 = W'($urandom_range(0, DEPTH-1));
        data1 = B'($urandom);
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    check("random_drained", req0 || req1, 0);
    check_mem();

    // Reset during an active grant with a second request pending.
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'hC3;
    @(negedge clk);
    check("pre_reset_ack0", ack0, 1);
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h3C;
    reset = 1'b1;
    @(negedge clk);
    check("reset_ack0", ack0, 0);
    check("reset_ack1", ack1, 0);
    check("reset_busy", init_busy, 1);
    check("reset_wr_en", wr_en, 0);
    data0 = 8'hE1; addr0 = 2'd2;
    @(negedge clk);
    reset = 1'b0;
    wait_ack(0, 20, n);
    check("post_reset_grant_latency", n, 6);
    req0 = 1'b0;
    wait_ack(1, 4, n);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    check_mem();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
